// File: rtl/spi_sclk_gen_pkg.sv
// spi_sclk_gen_pkg: SPI-wide constants shared by the master core blocks.
// Rev 1.0
`default_nettype none

package spi_sclk_gen_pkg;

  // Width of the SCLK divider and its down-counter.
  localparam int SPI_DIVIDER_LEN_DEFAULT = 8;

endpackage : spi_sclk_gen_pkg

`default_nettype wire

// File: rtl/spi_sclk_gen.sv
// spi_sclk_gen: divides i_clk by 2*(i_divider+1) into SCLK plus registered edge strobes.
// Rev 1.0
`default_nettype none

module spi_sclk_gen
  import spi_sclk_gen_pkg::*;
#(
  parameter int SPI_DIVIDER_LEN = SPI_DIVIDER_LEN_DEFAULT
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_enable,
  input  logic                       i_tx_start,
  input  logic                       i_last_clk,
  input  logic [SPI_DIVIDER_LEN-1:0] i_divider,
  output logic                       o_clk_out,
  output logic                       o_pos_edge,
  output logic                       o_neg_edge
);

  logic [SPI_DIVIDER_LEN-1:0] cnt_q, cnt_d;
  logic                       clk_q, clk_d;
  logic                       pos_q, pos_d;
  logic                       neg_q, neg_d;

  logic cnt_zero;
  logic cnt_one;
  logic div_zero;

  always_comb begin
    cnt_zero = (cnt_q == '0);
    cnt_one  = (cnt_q == SPI_DIVIDER_LEN'(1));
    div_zero = (i_divider == '0);

    // Divider is sampled only on reload, so a new value never shortens a running half-period.
    cnt_d = cnt_q - SPI_DIVIDER_LEN'(1);
    if (!i_enable || cnt_zero) begin
      cnt_d = i_divider;
    end

    // On the last bit a high SCLK may still fall, but a low SCLK never rises again.
    clk_d = clk_q;
    if (i_enable && cnt_zero && (!i_last_clk || clk_q)) begin
      clk_d = ~clk_q;
    end

    pos_d = (i_enable && !clk_q && cnt_one)
         || (div_zero && clk_q)
         || (div_zero && i_tx_start && !i_enable);

    neg_d = (i_enable && clk_q && cnt_one)
         || (div_zero && !clk_q && i_enable);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q <= '1;
      clk_q <= 1'b0;
      pos_q <= 1'b0;
      neg_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      clk_q <= clk_d;
      pos_q <= pos_d;
      neg_q <= neg_d;
    end
  end

  assign o_clk_out  = clk_q;
  assign o_pos_edge = pos_q;
  assign o_neg_edge = neg_q;

endmodule : spi_sclk_gen

`default_nettype wire

// File: tb/tb_spi_sclk_gen.sv
// tb_spi_sclk_gen: directed waveform vectors checked through an expected-value queue.
// Rev 1.0
`default_nettype none

module tb_spi_sclk_gen;

  logic       clk;
  logic       rst_n;
  logic       enable;
  logic       tx_start;
  logic       last_clk;
  logic [7:0] divider;
  logic       clk_out;
  logic       pos_edge;
  logic       neg_edge;

  spi_sclk_gen #(.SPI_DIVIDER_LEN(8)) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_enable   (enable),
    .i_tx_start (tx_start),
    .i_last_clk (last_clk),
    .i_divider  (divider),
    .o_clk_out  (clk_out),
    .o_pos_edge (pos_edge),
    .o_neg_edge (neg_edge)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Bit 2 = SCLK, bit 1 = pos strobe, bit 0 = neg strobe.
  typedef struct {
    logic [2:0] val;
    logic [2:0] care;
    string      tag;
    int         idx;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  function automatic string rep(input string c, input int n);
    string s;
    s = "";
    for (int i = 0; i < n; i++) s = {s, c};
    return s;
  endfunction

  function automatic logic chv(input byte c);
    return (c == "1");
  endfunction

  function automatic logic chc(input byte c);
    return (c != "-");
  endfunction

  // One vector per cycle; '-' in an expected string leaves that cycle unchecked.
  task automatic seg(input string tag, input logic rstn, input logic en, input logic st,
                     input logic lst, input logic [7:0] div,
                     input string ec, input string ep, input string eg);
    exp_t e;
    for (int i = 0; i < ec.len(); i++) begin
      rst_n    = rstn;
      enable   = en;
      tx_start = st;
      last_clk = lst;
      divider  = div;
      @(posedge clk);
      e.val  = {chv(ec[i]), chv(ep[i]), chv(eg[i])};
      e.care = {chc(ec[i]), chc(ep[i]), chc(eg[i])};
      e.tag  = tag;
      e.idx  = i + 1;
      q.push_back(e);
      #1;
    end
  endtask

  // Monitor: compares whatever the stimulus has queued against the DUT outputs.
  initial begin : monitor
    exp_t       cur;
    logic [2:0] act;
    string      nm [3];
    nm[0] = "neg_edge";
    nm[1] = "pos_edge";
    nm[2] = "clk_out";
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        cur = q.pop_front();
        act = {clk_out, pos_edge, neg_edge};
        for (int b = 0; b < 3; b++) begin
          if (cur.care[b]) begin
            n_checks++;
            if (act[b] !== cur.val[b])
              $display("FAIL %s[%0d] %s: got %b expected %b", cur.tag, cur.idx, nm[b],
                       act[b], cur.val[b]);
            else
              n_pass++;
          end
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL timeout: stimulus did not complete");
    $display("%0d/%0d checks passed", n_pass, n_checks + 1);
    $fatal(1);
  end

  initial begin : stimulus
    // Reset held while every input tries to make the outputs move.
    seg("reset", 1'b0, 1'b1, 1'b1, 1'b0, 8'd0, "000", "000", "000");

    // Enabled straight out of reset: counter starts at 8'hFF, so the first rise is 256 cycles away.
    seg("from_ff", 1'b1, 1'b1, 1'b0, 1'b0, 8'd2,
        {rep("0", 255), "1110"},
        {rep("0", 254), "1", rep("0", 4)},
        {rep("0", 257), "10"});

    // Divider 2: 3 high / 3 low, strobe in the cycle before each edge.
    seg("div2", 1'b1, 1'b1, 1'b0, 1'b0, 8'd2,
        "001110001110", "010000010000", "000010000010");

    // Divider changes only take effect at the next reload.
    seg("div3", 1'b1, 1'b1, 1'b0, 1'b0, 8'd3, "00111100001", "01000000010", "00000100000");
    seg("div5", 1'b1, 1'b1, 1'b0, 1'b0, 8'd5, "1110000001", "0000000010", "0010000000");

    // Enable dropped mid-period: level held, no strobes, resume after divider+1 cycles.
    seg("pre_hold", 1'b1, 1'b1, 1'b0, 1'b0, 8'd5, "11", "00", "00");
    seg("hold", 1'b1, 1'b0, 1'b0, 1'b0, 8'd2, "1111", "0000", "0000");
    seg("resume", 1'b1, 1'b1, 1'b0, 1'b0, 8'd2, "110001", "000010", "010000");

    // Last bit while high: one final fall, then SCLK stays parked low.
    seg("last_hi", 1'b1, 1'b1, 1'b0, 1'b1, 8'd2, "1100", "0000", "0100");
    seg("last_lo", 1'b1, 1'b1, 1'b0, 1'b1, 8'd2, "000000", "-00-00", "000000");

    // Divider 0: go strobe while idle, then SCLK toggles every cycle with alternating strobes.
    seg("idle0", 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, "00", "00", "00");
    seg("start0", 1'b1, 1'b0, 1'b1, 1'b0, 8'd0, "0", "1", "0");
    seg("div0", 1'b1, 1'b1, 1'b1, 1'b0, 8'd0, "10101", "01010", "10101");

    // Short reset pulse between clock edges while SCLK is high.
    #5 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    seg("after_rst", 1'b1, 1'b1, 1'b0, 1'b0, 8'd2, "00000", "00000", "00000");

    @(negedge clk);
    #1;
    n_checks++;
    if (q.size() != 0)
      $display("FAIL drain: got %0d queued entries expected 0", q.size());
    else
      n_pass++;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_spi_sclk_gen

`default_nettype wire
